// File: rtl/npc_pipe_pkg.sv
// npc_pipe_pkg
//   Shared definitions for the NPC pipeline boundaries (IFU->IDU->EXU->LSU):
//   payload structs carried by pipe_stage_reg instances and the NOP / bubble
//   encodings that are loaded into a boundary register when it is flushed.
//   No ports; imported with `import npc_pipe_pkg::*;`.
package npc_pipe_pkg;

  localparam int XLEN = 32;

  // addi x0, x0, 0 -- canonical RISC-V NOP, used as the instruction bubble.
  localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] instr;
  } ifu_idu_t;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] src1;
    logic [XLEN-1:0] src2;
    logic [4:0]      rd;
    logic            wen;
  } idu_exu_t;

  typedef struct packed {
    logic [XLEN-1:0] addr;
    logic [XLEN-1:0] wdata;
    logic [4:0]      rd;
    logic            mem_ren;
    logic            mem_wen;
  } exu_lsu_t;

  // Bubble for the fetch/decode boundary: pc cleared, instruction = NOP.
  function automatic ifu_idu_t ifu_idu_bubble();
    ifu_idu_t b;
    b.pc    = '0;
    b.instr = NOP_INSTR;
    return b;
  endfunction

endpackage

// File: rtl/pipe_stage_cell.sv
// pipe_stage_cell
//   One valid + payload register stage. Loads in_valid/in_data when advance is
//   high; the payload is only overwritten when a valid word arrives, so an
//   emptied stage keeps its last value. flush empties the stage and loads
//   BUBBLE_VALUE; rst (async, active-high) empties it and loads RESET_VALUE.
// Ports
//   clk, rst          clock / asynchronous active-high reset
//   flush             synchronous kill, wins over advance
//   advance           stage may take a new entry this cycle
//   in_valid, in_data incoming entry
//   valid, data       registered stage contents
module pipe_stage_cell #(
  parameter int              WIDTH        = 32,
  parameter logic [WIDTH-1:0] RESET_VALUE  = '0,
  parameter logic [WIDTH-1:0] BUBBLE_VALUE = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             advance,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             valid,
  output logic [WIDTH-1:0] data
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid <= 1'b0;
      data  <= RESET_VALUE;
    end else if (flush) begin
      valid <= 1'b0;
      data  <= BUBBLE_VALUE;
    end else if (advance) begin
      valid <= in_valid;
      if (in_valid) data <= in_data;
    end
  end

endmodule

// File: rtl/pipe_stage_reg.sv
// pipe_stage_reg
//   DEPTH-stage valid/ready pipeline register with back-pressure, synchronous
//   flush and configurable reset / bubble payloads. Replaces plain enable
//   registers between NPC pipeline stages.
// Ports
//   clk, rst              clock / asynchronous active-high reset
//   flush                 kill all in-flight entries at the next edge
//   in_valid, in_ready    upstream handshake, in_data payload
//   out_valid, out_ready  downstream handshake, out_data payload
// Configuration
//   PIPE_STAGE_REG_SKID_EN : adds a one-entry skid buffer in front of stage 0
//   so in_ready no longer depends combinationally on out_ready.
module pipe_stage_reg
  import npc_pipe_pkg::*;
#(
  parameter int               WIDTH        = 32,
  parameter int               DEPTH        = 1,
  parameter logic [WIDTH-1:0] RESET_VALUE  = '0,
  parameter logic [WIDTH-1:0] BUBBLE_VALUE = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data
);

  logic [DEPTH-1:0] vld;
  logic [WIDTH-1:0] dat [DEPTH];
  logic [DEPTH:0]   adv;
  logic             s0_valid;
  logic [WIDTH-1:0] s0_data;

  assign adv[DEPTH] = out_ready;

  genvar k;
  generate
    for (k = 0; k < DEPTH; k++) begin : g_stage
      // Stage k can move iff some stage at or after it is empty, or the
      // output drains. Written in closed form to avoid a chained comb loop.
      assign adv[k] = out_ready | ~(&vld[DEPTH-1:k]);

      if (k == 0) begin : g_first
        pipe_stage_cell #(
          .WIDTH(WIDTH), .RESET_VALUE(RESET_VALUE), .BUBBLE_VALUE(BUBBLE_VALUE)
        ) u_cell (
          .clk(clk), .rst(rst), .flush(flush), .advance(adv[0]),
          .in_valid(s0_valid), .in_data(s0_data),
          .valid(vld[0]), .data(dat[0])
        );
      end else begin : g_next
        pipe_stage_cell #(
          .WIDTH(WIDTH), .RESET_VALUE(RESET_VALUE), .BUBBLE_VALUE(BUBBLE_VALUE)
        ) u_cell (
          .clk(clk), .rst(rst), .flush(flush), .advance(adv[k]),
          .in_valid(vld[k-1]), .in_data(dat[k-1]),
          .valid(vld[k]), .data(dat[k])
        );
      end
    end
  endgenerate

  assign out_valid = vld[DEPTH-1];
  assign out_data  = dat[DEPTH-1];

`ifdef PIPE_STAGE_REG_SKID_EN
  logic             skid_valid;
  logic [WIDTH-1:0] skid_data;

  // The skid only captures a word that was accepted while stage 0 could not
  // move; it holds while stalled and empties itself when it drains.
  pipe_stage_cell #(
    .WIDTH(WIDTH), .RESET_VALUE(RESET_VALUE), .BUBBLE_VALUE(BUBBLE_VALUE)
  ) u_skid (
    .clk(clk), .rst(rst), .flush(flush),
    .advance(~skid_valid | adv[0]),
    .in_valid(in_valid & ~skid_valid & ~adv[0]),
    .in_data(in_data),
    .valid(skid_valid), .data(skid_data)
  );

  assign in_ready = ~skid_valid & ~flush;
  // A parked word always enters stage 0 before anything new.
  assign s0_valid = skid_valid | in_valid;
  assign s0_data  = skid_valid ? skid_data : in_data;
`else
  assign in_ready = adv[0] & ~flush;
  assign s0_valid = in_valid;
  assign s0_data  = in_data;
`endif

endmodule

// File: tb/tb_pipe_stage_reg.sv
module tb_pipe_stage_reg;
  import npc_pipe_pkg::*;

  localparam logic [31:0] RV3 = 32'hFFFF_0000;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;
  // DUT1: DEPTH=1, DUT2: DEPTH=2, DUT3: DEPTH=3 with NOP bubble
  logic f1, iv1, ir1, ov1, or1; logic [31:0] id1, od1;
  logic f2, iv2, ir2, ov2, or2; logic [31:0] id2, od2;
  logic f3, iv3, ir3, ov3, or3; logic [31:0] id3, od3;

  int checks = 0;
  int failures = 0;

  pipe_stage_reg #(.WIDTH(32), .DEPTH(1)) dut1 (
    .clk(clk), .rst(rst), .flush(f1), .in_valid(iv1), .in_ready(ir1),
    .in_data(id1), .out_valid(ov1), .out_ready(or1), .out_data(od1));

  pipe_stage_reg #(.WIDTH(32), .DEPTH(2)) dut2 (
    .clk(clk), .rst(rst), .flush(f2), .in_valid(iv2), .in_ready(ir2),
    .in_data(id2), .out_valid(ov2), .out_ready(or2), .out_data(od2));

  pipe_stage_reg #(.WIDTH(32), .DEPTH(3), .RESET_VALUE(RV3), .BUBBLE_VALUE(NOP_INSTR)) dut3 (
    .clk(clk), .rst(rst), .flush(f3), .in_valid(iv3), .in_ready(ir3),
    .in_data(id3), .out_valid(ov3), .out_ready(or3), .out_data(od3));

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    f1 = 0; iv1 = 0; or1 = 0; id1 = '0;
    f2 = 0; iv2 = 0; or2 = 0; id2 = '0;
    f3 = 0; iv3 = 0; or3 = 0; id3 = '0;
    #12;
    checks++; if (ov1 !== 1'b0 || od1 !== 32'h0) begin failures++;
      $display("FAIL reset_dut1 got v=%b d=%h want v=0 d=00000000", ov1, od1); end
    checks++; if (ov2 !== 1'b0 || od2 !== 32'h0) begin failures++;
      $display("FAIL reset_dut2 got v=%b d=%h want v=0 d=00000000", ov2, od2); end
    checks++; if (ov3 !== 1'b0 || od3 !== RV3) begin failures++;
      $display("FAIL reset_dut3 got v=%b d=%h want v=0 d=%h", ov3, od3, RV3); end
    rst = 1'b0;
    #1;
    checks++; if (ir1 !== 1'b1 || ir2 !== 1'b1 || ir3 !== 1'b1) begin failures++;
      $display("FAIL reset_in_ready got %b%b%b want 111", ir1, ir2, ir3); end
    cyc();
  endtask

  // DEPTH=2 stream 1..8 with out_ready held high.
  task automatic test_stream();
    or2 = 1'b1;
    for (int c = 0; c < 12; c++) begin
      iv2 = (c < 8);
      id2 = 32'(c + 1);
      #1;
      if (c < 8) begin
        checks++; if (ir2 !== 1'b1) begin failures++;
          $display("FAIL stream_in_ready c=%0d got %b want 1", c, ir2); end
      end
      cyc();
      checks++; if (ov2 !== ((c >= 1) && (c <= 8))) begin failures++;
        $display("FAIL stream_valid c=%0d got %b want %b", c, ov2, ((c >= 1) && (c <= 8))); end
      if (c >= 1 && c <= 8) begin
        checks++; if (od2 !== 32'(c)) begin failures++;
          $display("FAIL stream_data c=%0d got %h want %h", c, od2, 32'(c)); end
      end
    end
    iv2 = 1'b0;
  endtask

  // DEPTH=1 back-pressure: hold 0xA5 for 10 cycles while 0x5A is offered.
  task automatic test_backpressure();
    logic exp_ir;
    or1 = 1'b0; iv1 = 1'b1; id1 = 32'hA5;
    cyc();
    id1 = 32'h5A;
    for (int i = 0; i < 10; i++) begin
      #1;
`ifdef PIPE_STAGE_REG_SKID_EN
      exp_ir = (i == 0);
`else
      exp_ir = 1'b0;
`endif
      checks++; if (ir1 !== exp_ir) begin failures++;
        $display("FAIL bp_in_ready i=%0d got %b want %b", i, ir1, exp_ir); end
      cyc();
      checks++; if (ov1 !== 1'b1 || od1 !== 32'hA5) begin failures++;
        $display("FAIL bp_hold i=%0d got v=%b d=%h want v=1 d=000000a5", i, ov1, od1); end
    end
    or1 = 1'b1;
    #1;
`ifdef PIPE_STAGE_REG_SKID_EN
    exp_ir = 1'b0;
`else
    exp_ir = 1'b1;
`endif
    checks++; if (ir1 !== exp_ir) begin failures++;
      $display("FAIL bp_release_ready got %b want %b", ir1, exp_ir); end
    checks++; if (ov1 !== 1'b1 || od1 !== 32'hA5) begin failures++;
      $display("FAIL bp_release_first got v=%b d=%h want v=1 d=000000a5", ov1, od1); end
    cyc();
    iv1 = 1'b0;
    checks++; if (ov1 !== 1'b1 || od1 !== 32'h5A) begin failures++;
      $display("FAIL bp_release_second got v=%b d=%h want v=1 d=0000005a", ov1, od1); end
    cyc();
    checks++; if (ov1 !== 1'b0) begin failures++;
      $display("FAIL bp_empty_after got v=%b want 0", ov1); end
  endtask

  task automatic fill3(input logic [31:0] base);
    or3 = 1'b0; iv3 = 1'b1;
    for (int i = 0; i < 3; i++) begin
      id3 = base + 32'(i);
      cyc();
    end
    iv3 = 1'b0;
  endtask

  // DEPTH=3 full pipe, flush while 0x77 is offered.
  task automatic test_flush();
    fill3(32'h31);
    checks++; if (ov3 !== 1'b1 || od3 !== 32'h31) begin failures++;
      $display("FAIL flush_prefill got v=%b d=%h want v=1 d=00000031", ov3, od3); end
    f3 = 1'b1; iv3 = 1'b1; id3 = 32'h77;
    #1;
    checks++; if (ir3 !== 1'b0) begin failures++;
      $display("FAIL flush_in_ready got %b want 0", ir3); end
    cyc();
    f3 = 1'b0; iv3 = 1'b0;
    checks++; if (ov3 !== 1'b0 || od3 !== NOP_INSTR) begin failures++;
      $display("FAIL flush_bubble got v=%b d=%h want v=0 d=%h", ov3, od3, NOP_INSTR); end
    or3 = 1'b1;
    for (int i = 0; i < 4; i++) begin
      cyc();
      checks++; if (ov3 !== 1'b0 || od3 !== NOP_INSTR) begin failures++;
        $display("FAIL flush_drain i=%0d got v=%b d=%h want v=0 d=%h", i, ov3, od3, NOP_INSTR); end
    end
  endtask

  // Async reset in the middle of a cycle with DEPTH=3 full.
  task automatic test_async_reset();
    fill3(32'h41);
    checks++; if (ov3 !== 1'b1 || od3 !== 32'h41) begin failures++;
      $display("FAIL areset_prefill got v=%b d=%h want v=1 d=00000041", ov3, od3); end
    #3;
    rst = 1'b1;
    #1;
    checks++; if (ov3 !== 1'b0 || od3 !== RV3) begin failures++;
      $display("FAIL areset_immediate got v=%b d=%h want v=0 d=%h", ov3, od3, RV3); end
    #7;
    rst = 1'b0;
    #1;
    checks++; if (ir3 !== 1'b1 || ov3 !== 1'b0) begin failures++;
      $display("FAIL areset_after got ready=%b v=%b want ready=1 v=0", ir3, ov3); end
    cyc();
  endtask

  // Random handshakes on DEPTH=3 against an in-order queue.
  task automatic test_random();
    logic [31:0] sb[$];
    logic [31:0] seq;
    logic [31:0] exp;
    logic        prev_stall;
    logic [31:0] prev_data;
    seq = 32'h1000;
    prev_stall = 1'b0;
    prev_data = '0;
    for (int n = 0; n < 3030; n++) begin
      if (n < 3000) begin
        iv3 = ($urandom_range(0, 3) != 0);
        or3 = ($urandom_range(0, 2) != 0);
      end else begin
        iv3 = 1'b0;
        or3 = 1'b1;
      end
      id3 = seq;
      #1;
      if (prev_stall) begin
        checks++; if (ov3 !== 1'b1 || od3 !== prev_data) begin failures++;
          $display("FAIL rand_stable n=%0d got v=%b d=%h want v=1 d=%h", n, ov3, od3, prev_data); end
      end
      if (iv3 && ir3) begin
        sb.push_back(seq);
        seq = seq + 32'd1;
      end
      if (ov3 && or3) begin
        checks++;
        if (sb.size() == 0) begin failures++;
          $display("FAIL rand_dup n=%0d got d=%h want no output", n, od3); end
        else begin
          exp = sb.pop_front();
          if (od3 !== exp) begin failures++;
            $display("FAIL rand_order n=%0d got %h want %h", n, od3, exp); end
        end
      end
      prev_stall = ov3 && !or3;
      prev_data = od3;
      cyc();
    end
    checks++; if (sb.size() != 0) begin failures++;
      $display("FAIL rand_loss got %0d words left want 0", sb.size()); end
    checks++; if (seq < 32'h1100) begin failures++;
      $display("FAIL rand_accepts got %0d accepts want >= 256", seq - 32'h1000); end
  endtask

  initial begin
    test_reset();
    test_stream();
    test_backpressure();
    test_flush();
    test_async_reset();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog got timeout want finish");
    $fatal(1);
  end

endmodule
